// File: rtl/matmul_controller_pkg.sv
// Shared definitions for the matrix-multiply sequencer: datapath width, FSM encoding, default size.
package matmul_controller_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEFAULT_N = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // States in which a job is considered in progress.
    function automatic logic is_active(state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// Nested k (inner) / j / i (outer) index counter for the matrix-multiply sequencer.
module matmul_index_counter
    import matmul_controller_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             step_k_i,
    input  logic             step_ij_i,
    output logic [IDX_W-1:0] i_o,
    output logic [IDX_W-1:0] j_o,
    output logic [IDX_W-1:0] k_o,
    output logic             last_k_o,
    output logic             last_ij_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] j_q;
    logic [IDX_W-1:0] k_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            if (step_k_i) begin
                k_q <= (k_q == LAST) ? '0 : k_q + IDX_W'(1);
            end
            // j wraps into i; i itself wraps after the final element
            if (step_ij_i) begin
                if (j_q == LAST) begin
                    j_q <= '0;
                    i_q <= (i_q == LAST) ? '0 : i_q + IDX_W'(1);
                end else begin
                    j_q <= j_q + IDX_W'(1);
                end
            end
        end
    end

    assign i_o       = i_q;
    assign j_o       = j_q;
    assign k_o       = k_q;
    assign last_k_o  = (k_q == LAST);
    assign last_ij_o = (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/matmul_controller.sv
// Sequencer for C = A x B on the shared MAC: drives operand reads, MAC strobes and C writes.
// Optional abort support is compiled in when MATMUL_ABORT_EN is defined.
module matmul_controller
    import matmul_controller_pkg::*;
#(
    parameter int unsigned N      = DEFAULT_N,
    parameter int unsigned IDX_W  = $clog2(N),
    parameter int unsigned ADDR_W = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr
`ifdef MATMUL_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    state_e state_q;
    state_e state_d;

    logic rd_en_q;
    logic c_we_q;
    logic busy_q;
    logic done_q;
    logic mac_en_q;
    logic mac_clr_q;

    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] j_idx;
    logic [IDX_W-1:0] k_idx;
    logic             last_k;
    logic             last_ij;
    logic             clear_c;
    logic             step_k_c;
    logic             step_ij_c;
    logic             abort_hit;

    // Row-major address of (row, col).
    function automatic logic [ADDR_W-1:0] rc_addr(logic [IDX_W-1:0] r, logic [IDX_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c);
    endfunction

    assign clear_c   = (state_q == ST_IDLE) && start;
    assign step_k_c  = (state_q == ST_RUN);
    assign step_ij_c = (state_q == ST_WRITE);

    matmul_index_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (clear_c),
        .step_k_i  (step_k_c),
        .step_ij_i (step_ij_c),
        .i_o       (i_idx),
        .j_o       (j_idx),
        .k_o       (k_idx),
        .last_k_o  (last_k),
        .last_ij_o (last_ij)
    );

`ifdef MATMUL_ABORT_EN
    logic aborted_q;

    assign abort_hit = abort && is_active(state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
        end
    end

    assign aborted = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (last_k) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: state_d = last_ij ? ST_DONE : ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Strobes are registered from the state being entered so they line up with the Moore state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            c_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= (state_d == ST_RUN);
            c_we_q    <= (state_d == ST_WRITE);
            busy_q    <= is_active(state_d);
            done_q    <= (state_d == ST_DONE);
            mac_en_q  <= rd_en_q && !abort_hit;
            mac_clr_q <= rd_en_q && (k_idx == '0) && !abort_hit;
        end
    end

    always_comb begin
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        if (state_q == ST_RUN) begin
            a_addr = rc_addr(i_idx, k_idx);
            b_addr = rc_addr(k_idx, j_idx);
        end
        if (state_q == ST_WRITE) begin
            c_addr = rc_addr(i_idx, j_idx);
        end
    end

    assign rd_en   = rd_en_q;
    assign c_we    = c_we_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign mac_en  = mac_en_q;
    assign mac_clr = mac_clr_q;

endmodule

// File: tb/tb_matmul_controller.sv
// Self-checking bench for matmul_controller (N=4 and N=2 instances, behavioural memories and MAC).
module tb_matmul_controller;
    import matmul_controller_pkg::*;

    localparam int N = 4;
    localparam int L = N * N * (N + 2);
`ifdef MATMUL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rd_en;
        logic [3:0] a_addr;
        logic [3:0] b_addr;
        logic       mac_en;
        logic       mac_clr;
        logic       c_we;
        logic [3:0] c_addr;
        logic       busy;
        logic       done;
        logic       aborted;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;

    logic       rd_en, mac_en, mac_clr, c_we, busy, done, aborted;
    logic [3:0] a_addr, b_addr, c_addr;
    logic       s2_rd_en, s2_mac_en, s2_mac_clr, s2_c_we, s2_busy, s2_done;
    logic [1:0] s2_a_addr, s2_b_addr, s2_c_addr;
`ifdef MATMUL_ABORT_EN
    logic abort = 1'b0;
    logic s2_aborted;
`else
    assign aborted = 1'b0;
`endif

    outs_t act;
    assign act = {rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done, aborted};

    int vectors = 0;
    int miscompares = 0;
    int mt = 0;
    logic mab = 1'b0;

    always #5 clk = ~clk;

    matmul_controller #(.N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en),
        .mac_clr(mac_clr), .c_we(c_we), .c_addr(c_addr)
`ifdef MATMUL_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    matmul_controller #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(s2_busy), .done(s2_done),
        .rd_en(s2_rd_en), .a_addr(s2_a_addr), .b_addr(s2_b_addr), .mac_en(s2_mac_en),
        .mac_clr(s2_mac_clr), .c_we(s2_c_we), .c_addr(s2_c_addr)
`ifdef MATMUL_ABORT_EN
        , .abort(1'b0), .aborted(s2_aborted)
`endif
    );

    // Behavioural operand memories (1-cycle read), MAC and C memory for each instance.
    logic [DATA_W-1:0] A[16], B[16], C[16], a_q, b_q, acc;
    logic [DATA_W-1:0] A2[4], B2[4], C2[4], a2_q, b2_q, acc2;

    always @(posedge clk) begin
        if (rd_en) begin
            a_q <= A[a_addr];
            b_q <= B[b_addr];
        end
        if (mac_en) acc <= mac_clr ? DATA_W'(a_q * b_q) : DATA_W'(acc + a_q * b_q);
        if (c_we) C[c_addr] <= acc;
    end

    always @(posedge clk) begin
        if (s2_rd_en) begin
            a2_q <= A2[s2_a_addr];
            b2_q <= B2[s2_b_addr];
        end
        if (s2_mac_en) acc2 <= s2_mac_clr ? DATA_W'(a2_q * b2_q) : DATA_W'(acc2 + a2_q * b2_q);
        if (s2_c_we) C2[s2_c_addr] <= acc2;
    end

    function automatic outs_t mk(int rd, int a, int b, int me, int mc, int we, int ca, int bs, int dn);
        outs_t o;
        o = '0;
        o.rd_en = 1'(rd); o.a_addr = 4'(a); o.b_addr = 4'(b);
        o.mac_en = 1'(me); o.mac_clr = 1'(mc); o.c_we = 1'(we);
        o.c_addr = 4'(ca); o.busy = 1'(bs); o.done = 1'(dn);
        return o;
    endfunction

    // Expected outputs t cycles into a job, from element/phase arithmetic.
    function automatic outs_t model_out(int t, logic ab);
        outs_t o;
        int e, p, i, j;
        o = '0;
        o.aborted = ab;
        if (t >= 1 && t <= L) begin
            e = (t - 1) / (N + 2);
            p = (t - 1) % (N + 2);
            i = e / N;
            j = e % N;
            o.busy = 1'b1;
            if (p < N) begin
                o.rd_en = 1'b1;
                o.a_addr = 4'(i * N + p);
                o.b_addr = 4'(p * N + j);
            end
            if (p >= 1 && p <= N) begin
                o.mac_en = 1'b1;
                o.mac_clr = (p == 1);
            end
            if (p == N + 1) begin
                o.c_we = 1'b1;
                o.c_addr = 4'(i * N + j);
            end
        end else if (t == L + 1) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic chk(input string name, input outs_t got, input outs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Drive inputs for the coming edge and advance the reference model across it.
    task automatic drive(input logic st, input logic rs, input logic ab);
        start = st;
        rst = rs;
`ifdef MATMUL_ABORT_EN
        abort = ab;
`endif
        mab = 1'b0;
        if (rs) mt = 0;
        else if (mt == 0) mt = st ? 1 : 0;
        else if (mt == L + 1) mt = 0;
        else if (ABORT_EN && ab) begin
            mt = 0;
            mab = 1'b1;
        end else mt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0);
        start2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic randomize_ab();
        for (int x = 0; x < 16; x++) begin
            A[x] = DATA_W'($urandom_range(0, 255));
            B[x] = DATA_W'($urandom_range(0, 255));
        end
    endtask

    task automatic check_c(input string name);
        int bad;
        logic [DATA_W-1:0] s;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = DATA_W'(s + A[i*N+k] * B[k*N+j]);
                if (C[i*N+j] !== s) bad++;
            end
        end
        chk_int(name, bad, 0);
    endtask

    vec_t tbl[$];
    int   cur, done_at, done2_at, quiet, we_n, dn_n;
    int   busy98, busy99, rd99;
    int   wq[$];
    logic st_r, rs_r, ab_r;

    initial begin
        tbl.push_back('{0,  mk(0, 0,  0, 0, 0, 0,  0, 0, 0)});
        tbl.push_back('{1,  mk(1, 0,  0, 0, 0, 0,  0, 1, 0)});
        tbl.push_back('{2,  mk(1, 1,  4, 1, 1, 0,  0, 1, 0)});
        tbl.push_back('{4,  mk(1, 3, 12, 1, 0, 0,  0, 1, 0)});
        tbl.push_back('{5,  mk(0, 0,  0, 1, 0, 0,  0, 1, 0)});
        tbl.push_back('{6,  mk(0, 0,  0, 0, 0, 1,  0, 1, 0)});
        tbl.push_back('{7,  mk(1, 0,  1, 0, 0, 0,  0, 1, 0)});
        tbl.push_back('{37, mk(1, 4,  2, 0, 0, 0,  0, 1, 0)});
        tbl.push_back('{38, mk(1, 5,  6, 1, 1, 0,  0, 1, 0)});
        tbl.push_back('{39, mk(1, 6, 10, 1, 0, 0,  0, 1, 0)});
        tbl.push_back('{40, mk(1, 7, 14, 1, 0, 0,  0, 1, 0)});
        tbl.push_back('{41, mk(0, 0,  0, 1, 0, 0,  0, 1, 0)});
        tbl.push_back('{42, mk(0, 0,  0, 0, 0, 1,  6, 1, 0)});
        tbl.push_back('{96, mk(0, 0,  0, 0, 0, 1, 15, 1, 0)});
        tbl.push_back('{97, mk(0, 0,  0, 0, 0, 0,  0, 0, 1)});
        tbl.push_back('{98, mk(0, 0,  0, 0, 0, 0,  0, 0, 0)});

        A2[0] = 16'd1; A2[1] = 16'd2; A2[2] = 16'd3; A2[3] = 16'd4;
        B2[0] = 16'd5; B2[1] = 16'd6; B2[2] = 16'd7; B2[3] = 16'd8;
        randomize_ab();

        // Fixed N=4 trace: reset state, element timing, element (1,2) addresses, done.
        do_reset();
        cur = 0;
        foreach (tbl[v]) begin
            while (cur < tbl[v].cyc) begin
                @(negedge clk);
                start = 1'b0;
                cur++;
            end
            chk($sformatf("trace_c%0d", tbl[v].cyc), act, tbl[v].exp);
            if (tbl[v].cyc == 0) start = 1'b1;
        end
        check_c("trace_result");

        // N=2 reference job.
        do_reset();
        start2 = 1'b1;
        cur = 0; done_at = -1; we_n = 0;
        wq.delete();
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            start2 = 1'b0;
            cur++;
            if (s2_c_we) wq.push_back(int'(s2_c_addr));
            if (s2_done && done_at < 0) done_at = cur;
            if (cur == 16) chk_int("n2_busy_c16", int'(s2_busy), 1);
            if (cur == 17) chk_int("n2_busy_c17", int'(s2_busy), 0);
`ifdef MATMUL_ABORT_EN
            if (s2_aborted) we_n++;
`endif
        end
        chk_int("n2_done_cycle", done_at, 17);
        chk_int("n2_cwe_count", wq.size(), 4);
        for (int k = 0; k < 4; k++) chk_int($sformatf("n2_caddr%0d", k), (wq.size() > k) ? wq[k] : -1, k);
        chk_int("n2_c00", int'(C2[0]), 19);
        chk_int("n2_c01", int'(C2[1]), 22);
        chk_int("n2_c10", int'(C2[2]), 43);
        chk_int("n2_c11", int'(C2[3]), 50);
        chk_int("n2_no_abort", we_n, 0);

        // start held high across two jobs.
        do_reset();
        start = 1'b1;
        cur = 0; done_at = -1; done2_at = -1; busy98 = -1; busy99 = -1; rd99 = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            cur++;
            if (done && done_at < 0) done_at = cur;
            else if (done && done2_at < 0) done2_at = cur;
            if (cur == 98) busy98 = int'(busy);
            if (cur == 99) begin
                busy99 = int'(busy);
                rd99 = int'(rd_en);
            end
        end
        start = 1'b0;
        chk_int("held_done1", done_at, 97);
        chk_int("held_idle_busy", busy98, 0);
        chk_int("held_restart_busy", busy99, 1);
        chk_int("held_restart_rd", rd99, 1);
        chk_int("held_done2", done2_at, 195);

        // Reset in the DRAIN cycle of element 5.
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cur = 1;
        while (cur < 35) begin
            @(negedge clk);
            cur++;
        end
        chk("drain_e5", act, model_out(35, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_job", act, '0);
        quiet = 0;
        repeat (30) begin
            @(negedge clk);
            if (mac_en || c_we || busy || done || rd_en) quiet++;
        end
        chk_int("quiet_after_rst", quiet, 0);

`ifdef MATMUL_ABORT_EN
        // Abort in RUN of element 3.
        do_reset();
        start = 1'b1;
        cur = 0; we_n = 0; dn_n = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            start = 1'b0;
            cur++;
            if (c_we) we_n++;
            if (done) dn_n++;
            if (cur == 20) abort = 1'b1;
            if (cur == 21) begin
                abort = 1'b0;
                chk_int("abort_run_pulse", int'(aborted), 1);
                chk_int("abort_run_idle", int'(busy | rd_en | mac_en), 0);
            end
            if (cur == 22) chk_int("abort_run_pulse_end", int'(aborted), 0);
        end
        chk_int("abort_run_writes", we_n, 3);
        chk_int("abort_run_done", dn_n, 0);

        // Abort during WRITE, then abort+start together in IDLE.
        do_reset();
        start = 1'b1;
        cur = 0;
        while (cur < 6) begin
            @(negedge clk);
            start = 1'b0;
            cur++;
        end
        chk_int("abort_wr_we", int'(c_we), 1);
        abort = 1'b1;
        @(negedge clk);
        chk_int("abort_wr_idle", int'({busy, c_we, aborted}), 1);
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk_int("abort_idle_start", int'({busy, rd_en, aborted}), 6);
`endif

        // Randomized run against the reference model.
        do_reset();
        randomize_ab();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            chk("rand", act, model_out(mt, mab));
            if (mt == L + 1) begin
                check_c("rand_result");
                randomize_ab();
            end
            st_r = (n >= 1500 && n < 1800) ? 1'b1 : ($urandom_range(0, 3) == 0);
            rs_r = ($urandom_range(0, 499) == 0);
            ab_r = ABORT_EN && ($urandom_range(0, 99) == 0);
            drive(st_r, rs_r, ab_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_controller.md
# matmul_controller

Sequencer for the matrix-multiplication datapath: computes C = A × B for square N×N matrices by driving read addresses into the A and B operand memories, sequencing the shared multiply-accumulate (MAC) unit with clear/enable strobes, and writing each finished element to the C memory. It sits between the SoC-side start/done handshake and the memories/MAC, which use the shared 16-bit data width. It holds no matrix data itself.

## Interface
- `N`, 4: matrix dimension, ≥ 2.
- `IDX_W`, `$clog2(N)`: width of the i/j/k index counters.
- `ADDR_W`, `$clog2(N*N)`: width of every memory address, row-major (`addr = row*N + col`).
- `clk` in 1: the block's only clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `busy` out 1: high while a job is in progress (RUN, DRAIN, WRITE).
- `done` out 1: one-cycle pulse when the job completes.
- `rd_en` out 1: read strobe to the A and B memories. Read latency is 1 cycle.
- `a_addr` out ADDR_W: A read address, `i*N+k`.
- `b_addr` out ADDR_W: B read address, `k*N+j`.
- `mac_en` out 1: MAC update strobe; operands are valid on the memory outputs in this cycle.
- `mac_clr` out 1: with `mac_en`, the MAC loads the product instead of accumulating it.
- `c_we` out 1: C write strobe; the MAC result is the write data.
- `c_addr` out ADDR_W: C write address, `i*N+j`.
- `abort` in 1, and `aborted` out 1: present only when `MATMUL_ABORT_EN` is defined.

## Operation
- States are IDLE, RUN, DRAIN, WRITE and DONE.
- IDLE:
  - All strobes are low.
  - `start`=1 → RUN, with i, j, k cleared to 0.
- RUN:
  - `rd_en`=1, with `a_addr`/`b_addr` decoded from i, j, k.
  - k increments each cycle.
  - At k=N-1: k wraps to 0 and the next state is DRAIN.
- DRAIN:
  - `rd_en`=0.
  - This cycle lets the last product enter the MAC.
  - Next state is WRITE.
- WRITE:
  - `c_we`=1 and `c_addr`=`i*N+j`.
  - Then j increments. If j=N-1, j wraps to 0 and i increments.
  - If i=N-1 and j=N-1 the next state is DONE; otherwise RUN.
- DONE:
  - `done`=1 and `busy`=0.
  - Next state is IDLE unconditionally.
- MAC strobes:
  - `mac_en` is `rd_en` delayed by one register stage.
  - `mac_clr` is `mac_en` AND (the delayed k == 0).
- Output decode:
  - `rd_en`, the addresses, `c_we`, `busy` and `done` are decoded from the state and counters (Moore).
  - The addresses are 0 outside RUN and WRITE.
- Index arithmetic is unsigned with no saturation. The maximum index product, (N-1)*N + (N-1) = N*N-1, fits in ADDR_W.
- `start` outside IDLE, including in DONE, is ignored. No request is queued.

## Timing
- Reset values:
  - State is IDLE; i, j and k are 0.
  - The `mac_en` delay register is 0, so no stray `mac_en` appears after reset.
  - All outputs are 0, including `aborted`.
- Reset mid-job: the job is discarded; no `done` and no further `c_we`.
- Cycle numbering: `start` is sampled at edge 0 and the first RUN cycle is cycle 1.
- Each element takes N+2 cycles: N read cycles, 1 DRAIN, 1 WRITE.
- `mac_en` is high in cycles 2..N+1 of each element; `mac_clr` is high in cycle 2.
- `c_we` is in cycle N+2 of each element; the MAC result registered at the end of DRAIN is stable there.
- `done` is in cycle N·N·(N+2)+1. For N=4 that is cycle 97; for N=2 it is cycle 17.
- `busy` is high in cycles 1..N·N·(N+2).
- Back-to-back jobs: the earliest accepted restart is `start` sampled in the IDLE cycle right after DONE.

## Configuration
- `MATMUL_ABORT_EN` defined:
  - `abort` is sampled in RUN, DRAIN and WRITE and forces IDLE on the next edge.
  - The clock cycle containing the abort still completes its Moore outputs. If it is a WRITE cycle, that write happens.
  - The `mac_en` delay register is cleared.
  - `aborted` pulses for 1 cycle, the cycle after abort is sampled.
  - `done` does not pulse for an aborted job.
  - `abort` in IDLE or DONE is ignored.
- `MATMUL_ABORT_EN` undefined: the `abort` and `aborted` ports and all abort logic are absent. The behaviour is otherwise identical.

## Structure
- Shared definitions header:
  - Data width 16, the same constant the datapath uses.
  - The state encodings: IDLE=0, RUN=1, DRAIN=2, WRITE=3, DONE=4.
  - The default N.
- Sub-module `matmul_index_counter`:
  - The nested k/j/i counter with `step_k`, `step_ij` and `clear` inputs.
  - `last_k` and `last_ij` outputs.
  - The controller owns the FSM and the strobe/address decode.

## Test plan
- N=2 with a behavioural MAC and memories, A=[1,2;3,4], B=[5,6;7,8]:
  - C must be [19,22;43,50].
  - `done` in cycle 17; 4 `c_we` pulses at c_addr 0,1,2,3.
- N=4 address trace:
  - In RUN cycles of element (i=1, j=2), `a_addr` = 4,5,6,7 and `b_addr` = 2,6,10,14.
  - `mac_clr` only on the first `mac_en` of each element.
- `start` held high continuously:
  - The first job completes with `done` at cycle 97 (N=4).
  - The second job starts from the IDLE cycle after DONE.
  - No `start` pulse is accepted while `busy`.
- `rst` asserted in DRAIN of element 5:
  - Next cycle all outputs are 0 and state is IDLE.
  - No `mac_en` and no `c_we` until a new `start`.
- `MATMUL_ABORT_EN`, `abort` in a RUN cycle of element 3:
  - `aborted`=1 for 1 cycle, then IDLE.
  - Exactly 3 `c_we` pulses in total and no `done`.
- `MATMUL_ABORT_EN`, `abort` during a WRITE cycle:
  - That write occurs; IDLE follows.
  - `abort` while IDLE together with `start`=1 → the job starts normally.
